// File: rtl/aes_io_pkg.sv
// rtl/aes_io_pkg.sv - shared constants and types for the AES byte-serial I/O stage
package aes_io_pkg;

    localparam int NBYTES = 16;
    localparam int BW     = 8;
    localparam int BLK_W  = NBYTES * BW;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    typedef logic [BW-1:0]    byte_t;
    typedef logic [BLK_W-1:0] block_t;

endpackage

// File: rtl/aes_byte_ser.sv
// rtl/aes_byte_ser.sv - parallel-load, MSB-first byte serializer holding its byte until accepted
module aes_byte_ser #(
    parameter int NBYTES = 16,
    parameter int BW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [NBYTES*BW-1:0] din_i,
    input  logic                 valid_i,
    input  logic                 ready_i,
    output logic [BW-1:0]        dout_o
);
    import aes_io_pkg::*;

    localparam int BLKW = NBYTES * BW;

    logic [BLKW-1:0] shreg_q, shreg_d;

    // The register only moves on a completed transfer, so a stalled byte stays put.
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = din_i;
        end else if (valid_i && ready_i) begin
            shreg_d = {shreg_q[BLKW-BW-1:0], {BW{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign dout_o = shreg_q[BLKW-1 -: BW];

endmodule

// File: rtl/aes_io_stage.sv
// rtl/aes_io_stage.sv - byte-serial load/unload wrapper around the 128-bit AES round core
module aes_io_stage #(
    parameter int NBYTES = 16,
    parameter int BW     = 8,
    parameter int CW     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [BW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 core_start,
    output logic [NBYTES*BW-1:0] core_din,
    input  logic                 core_done,
    input  logic [NBYTES*BW-1:0] core_dout,
    output logic                 out_valid,
    output logic [BW-1:0]        out_data,
    input  logic                 out_ready,
    output logic                 busy
);
    import aes_io_pkg::*;

    localparam int            BLKW = NBYTES * BW;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BLKW-1:0] in_reg_q, in_reg_d;
    logic [CW-1:0]   lane;
    logic            capture;

    // First accepted byte goes to the top lane.
    assign lane = LAST - cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_reg_d   = in_reg_q;
        capture    = 1'b0;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_reg_d[int'(lane)*BW +: BW] = in_data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            in_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_reg_q <= in_reg_d;
        end
    end

    assign core_din = in_reg_q;
    assign busy     = (state_q != LOAD);

    aes_byte_ser #(
        .NBYTES (NBYTES),
        .BW     (BW)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (capture),
        .din_i   (core_dout),
        .valid_i (out_valid),
        .ready_i (out_ready),
        .dout_o  (out_data)
    );

endmodule

// File: tb/tb_aes_io_stage.sv
// tb/tb_aes_io_stage.sv - directed and randomized bench for aes_io_stage with a byte-queue reference
module tb_aes_io_stage;
    import aes_io_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid;
    byte_t  in_data;
    logic   in_ready;
    logic   core_start;
    block_t core_din;
    logic   core_done;
    block_t core_dout;
    logic   out_valid;
    byte_t  out_data;
    logic   out_ready;
    logic   busy;

    int passed = 0;
    int total  = 0;

    byte_t  blk [NBYTES];
    block_t res;

    localparam block_t FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_io_stage #(.NBYTES(16), .BW(8), .CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .core_start (core_start),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    task automatic chk(input string tag, input block_t obs, input block_t exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {{(BLK_W-1){1'b0}}, obs}, {{(BLK_W-1){1'b0}}, exp});
    endtask

    task automatic chk8(input string tag, input byte_t obs, input byte_t exp);
        chk(tag, {{(BLK_W-BW){1'b0}}, obs}, {{(BLK_W-BW){1'b0}}, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic block_t rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected block: accepted bytes concatenated in arrival order.
    function automatic block_t pack_blk();
        block_t r = '0;
        for (int i = 0; i < NBYTES; i++) r = {r[BLK_W-BW-1:0], blk[i]};
        return r;
    endfunction

    task automatic rand_blk();
        for (int i = 0; i < NBYTES; i++) blk[i] = byte_t'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_core_start"}, core_start, 1'b0);
        chk({tag, "_core_din"}, core_din, '0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk8({tag, "_out_data"}, out_data, 8'h00);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic load_block(input bit gapped);
        block_t exp;
        exp = pack_blk();
        for (int i = 0; i < NBYTES; i++) begin
            if (gapped && i > 0) begin
                in_valid = 1'b0;
                in_data  = byte_t'($urandom);
                #1;
                chk1("gap_in_ready", in_ready, 1'b1);
                step();
            end
            in_valid = 1'b1;
            in_data  = blk[i];
            #1;
            chk1("load_in_ready", in_ready, 1'b1);
            chk1("load_busy", busy, 1'b0);
            chk1("load_no_start", core_start, 1'b0);
            step();
        end
        in_valid = 1'b0;
        in_data  = byte_t'($urandom);
        chk1("start_pulse", core_start, 1'b1);
        chk("start_core_din", core_din, exp);
        chk1("start_busy", busy, 1'b1);
        chk1("start_in_ready", in_ready, 1'b0);
        step();
        chk1("start_single", core_start, 1'b0);
        chk("wait_core_din", core_din, exp);
    endtask

    task automatic core_run(input block_t r, input int delay);
        block_t exp;
        exp = pack_blk();
        for (int d = 0; d < delay; d++) begin
            in_valid = 1'($urandom);
            in_data  = byte_t'($urandom);
            #1;
            chk1("wait_in_ready", in_ready, 1'b0);
            chk1("wait_out_valid", out_valid, 1'b0);
            chk1("wait_no_start", core_start, 1'b0);
            chk("wait_din_stable", core_din, exp);
            step();
        end
        in_valid  = 1'b0;
        core_done = 1'b1;
        core_dout = r;
        #1;
        chk1("done_cycle_out_valid", out_valid, 1'b0);
        step();
        core_done = 1'b0;
        core_dout = rand_block();
        chk1("out_valid_after_done", out_valid, 1'b1);
        chk8("first_out_byte", out_data, r[BLK_W-1 -: BW]);
        chk("unload_core_din", core_din, exp);
    endtask

    task automatic unload(input block_t r, input int stall_at);
        byte_t exp_b;
        logic  rdy;
        int    tries;
        int    forced;
        for (int k = 0; k < NBYTES; k++) begin
            exp_b  = r[(NBYTES-1-k)*BW +: BW];
            tries  = 0;
            forced = 0;
            rdy    = 1'b0;
            while (!rdy) begin
                if (k == stall_at && forced < 3) begin
                    rdy = 1'b0;
                    forced++;
                end else if (tries >= 6) begin
                    rdy = 1'b1;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                tries++;
                out_ready = rdy;
                core_done = ($urandom_range(0, 3) == 0);
                core_dout = rand_block();
                #1;
                chk1("unload_out_valid", out_valid, 1'b1);
                chk8("unload_out_data", out_data, exp_b);
                chk1("unload_in_ready", in_ready, 1'b0);
                step();
            end
        end
        out_ready = 1'b0;
        core_done = 1'b0;
        chk1("after_unload_out_valid", out_valid, 1'b0);
        chk1("after_unload_in_ready", in_ready, 1'b1);
        chk1("after_unload_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        core_done = 1'b0;
        core_dout = '0;
        out_ready = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();
        check_reset_vals("post_release");

        // FIPS-197 plaintext/ciphertext, stall three cycles on the 6a byte.
        for (int i = 0; i < NBYTES; i++) blk[i] = byte_t'(i * 17);
        load_block(1'b0);
        chk("fips_core_din", core_din, 128'h00112233445566778899aabbccddeeff);
        core_run(FIPS_CT, 2);
        unload(FIPS_CT, 4);

        // Alternating in_valid, noise on in_valid while waiting for the core.
        rand_blk();
        load_block(1'b1);
        res = rand_block();
        core_run(res, 5);
        unload(res, -1);

        // Reset after seven accepted bytes discards the partial block.
        rand_blk();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = blk[i];
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_vals("mid_load_reset");
        step();
        rst_n = 1'b1;
        step();
        rand_blk();
        load_block(1'b0);
        res = rand_block();
        core_run(res, 1);
        unload(res, 9);

        // Stray core_done while idle must not be captured or change state.
        core_done = 1'b1;
        core_dout = rand_block();
        step();
        core_done = 1'b0;
        chk1("stray_in_ready", in_ready, 1'b1);
        chk1("stray_busy", busy, 1'b0);
        chk1("stray_out_valid", out_valid, 1'b0);
        chk("stray_core_din", core_din, pack_blk());

        // Back-to-back blocks: each load begins right after the last output transfer.
        for (int b = 0; b < 2; b++) begin
            rand_blk();
            load_block(1'b0);
            res = rand_block();
            core_run(res, b);
            unload(res, int'($urandom_range(0, 15)));
        end

        // Reset while unloading drops out_valid without waiting for a clock.
        rand_blk();
        load_block(1'b0);
        res = rand_block();
        core_run(res, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_unload_reset");
        step();
        rst_n = 1'b1;
        step();
        check_reset_vals("final_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_io_stage.md
Name: aes_io_stage

Overview:
Byte-serial I/O stage between the external byte bus and the 128-bit gate-level AES round core, which is built from library cells.
- Collects 16 input bytes into a 128-bit state register and issues a one-cycle start pulse to the core.
- Waits for the core's done strobe, captures the result, and streams it out as 16 bytes.
- Both byte interfaces use valid/ready handshakes.
- Holds exactly one block in flight.

Parameters:
NBYTES, 16, bytes per block; the block width is NBYTES*8.
BW, 8, byte width in bits.
CW, 4, byte counter width; must equal clog2(NBYTES).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  input byte valid.
in_data  in  BW  input byte.
in_ready  out  1  stage accepts an input byte this cycle.
core_start  out  1  one-cycle pulse; core_din is valid and stable from this pulse until core_done.
core_din  out  NBYTES*BW  assembled input block.
core_done  in  1  one-cycle pulse from the core; core_dout is valid in the same cycle.
core_dout  in  NBYTES*BW  core result block.
out_valid  out  1  output byte valid.
out_data  out  BW  output byte.
out_ready  in  1  consumer accepts the output byte.
busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (async assert, sync release): state=LOAD, cnt=0, in_reg=0, out_reg=0. Outputs: in_ready=1, core_start=0, core_din=0, out_valid=0, out_data=0, busy=0.
- Byte order: the first byte accepted lands in bits [127:120] (MSB-first). The first byte emitted is core_dout[127:120].
- State LOAD: in_ready=1.
  - On in_valid&in_ready: write in_data into the byte lane selected by cnt; cnt<=cnt+1.
  - The 16th accept (cnt==15) sets cnt<=0 and moves to START.
- State START: core_start=1 for exactly one cycle, in_ready=0, then go to WAIT.
- State WAIT: in_ready=0. Hold core_din stable.
  - On core_done: out_reg<=core_dout, cnt<=0, go to UNLOAD.
  - No timeout; the stage waits indefinitely.
- State UNLOAD: out_valid=1, out_data=out_reg[127:120].
  - On out_ready: shift out_reg left by 8 bits and cnt<=cnt+1.
  - The 16th transfer (cnt==15) returns to LOAD with cnt<=0 and out_valid=0 in the next cycle.
  - out_data must not change while out_valid&!out_ready.
- Latency (all waits zero):
  - Last input byte accepted at cycle N -> core_start at N+1.
  - core_done at cycle M -> out_valid=1 at M+1.
  - A fully streaming output takes 16 cycles.
- Stray core_done in LOAD, START or UNLOAD is ignored; no state change and no capture.
- in_valid outside LOAD: not accepted (in_ready=0), and the data is not modified.
- The counter wraps 15->0 only through the state transitions above; there is no other wrap.
- Reset mid-operation: immediate return to reset values. A partially loaded block is discarded and out_valid drops asynchronously.
- Back-to-back blocks: the first byte of the next block may be accepted in the cycle after the last output transfer.
- busy=1 in START, WAIT and UNLOAD.

Decomposition:
- Shared package aes_io_pkg holds:
  - constants NBYTES=16, BW=8, BLK_W=128;
  - typedef state_t {LOAD, START, WAIT, UNLOAD} as a 2-bit encoding;
  - typedef byte_t (logic [7:0]) and block_t (logic [127:0]).
- One sub-module, aes_byte_ser: the parallel-load, left-shift output serializer with a valid/ready hold.
- FSM, counter and input lane-write logic stay in the top.

Test Plan:
1. Reset then load the FIPS-197 plaintext bytes 00 11 22 … ff with in_valid held high -> core_din=00112233445566778899aabbccddeeff and a single core_start pulse one cycle after the 16th accept.
2. Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a on core_done -> out bytes 69, c4, e0 … 5a in order, out_valid rising the cycle after done.
3. Random out_ready stalls, e.g. low for 3 cycles at byte 5 -> out_data holds 6a while stalled, no byte lost or duplicated, all 16 bytes delivered.
4. Gapped in_valid (alternating) plus in_valid asserted during WAIT -> only 16 bytes are captured, in_ready=0 in WAIT, and core_din is unchanged.
5. rst_n pulsed low after 7 input bytes -> all outputs return to reset values; a fresh 16-byte load then produces the correct core_din.
6. Stray core_done in LOAD, then two back-to-back blocks -> no state change for the stray pulse; the second block loads in the cycle after the last output byte.
